exc_ctrl: RTL and testbench

- Exception/interrupt sequencer for the 5-stage MIPS pipeline. It sits between the M stage and CP0.
- Merges the M-stage exception code into CP0's ExcCode_in/PC/BD_in, and watches CP0's interrupt/exception outputs.
- When an event is taken, it flushes the pipeline and redirects fetch to the handler, or to EPC on eret.
- A small FSM holds the flush for a configurable drain period and tracks the resume PC for post-flush bubbles.

---
 rtl/exc_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the M stage and CP0: merges exception info,
// flushes and redirects fetch on a taken event or eret. Optional counters: EXC_STATS_EN.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 2
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_carried_m,
  input  logic [4:0]  exc_new_m,
  input  logic        eret_m,
  input  logic        cp0_interrupt,
  input  logic        cp0_exception,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  cp0_exccode,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic        cp0_eret,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
`ifdef EXC_STATS_EN
  output logic [15:0] int_count,
  output logic [15:0] exc_count,
`endif
  output logic        busy
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        post_flush, post_flush_nx;
  logic [31:0] resume_pc, resume_pc_nx;

  logic        take, do_eret, redir;
  logic [31:0] target;

  // take is combinational through CP0 so the redirect happens in the event cycle
  assign take    = (state == RUN) && (cp0_interrupt || cp0_exception);
  assign do_eret = (state == RUN) && valid_m && eret_m && !take;
  assign redir   = take || do_eret;
  assign target  = take ? HANDLER_ADDR : cp0_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      cnt        <= '0;
      post_flush <= 1'b0;
      resume_pc  <= HANDLER_ADDR;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      post_flush <= post_flush_nx;
      resume_pc  <= resume_pc_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    post_flush_nx = post_flush;
    resume_pc_nx  = resume_pc;
    case (state)
      RUN: begin
        if (redir) begin
          resume_pc_nx  = target;
          post_flush_nx = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            cnt_nx   = CNT_INIT;
          end
        end else if (valid_m) begin
          post_flush_nx = 1'b0;
        end
      end
      FLUSH: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // Every output is held at 0 while reset is low, including the pass-through paths
  always_comb begin
    cp0_exccode = '0;
    cp0_pc      = '0;
    cp0_bd      = 1'b0;
    cp0_eret    = 1'b0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    busy        = 1'b0;
    if (reset) begin
      if (state == RUN && valid_m)
        cp0_exccode = (exc_carried_m != 5'd0) ? exc_carried_m : exc_new_m;
      if (!valid_m && post_flush) begin
        cp0_pc = resume_pc;
        cp0_bd = 1'b0;
      end else begin
        cp0_pc = pc_m;
        cp0_bd = bd_m;
      end
      cp0_eret    = do_eret;
      flush       = redir || (state == FLUSH);
      pc_redirect = redir;
      redirect_pc = redir ? target : 32'd0;
      busy        = (state == FLUSH);
    end
  end

`ifdef EXC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_count <= '0;
      exc_count <= '0;
    end else if (take) begin
      if (cp0_interrupt) begin
        if (int_count != 16'hFFFF) int_count <= int_count + 16'd1;
      end else begin
        if (exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized + directed bench for exc_ctrl against a cycle-level behavioural model.
module tb_exc_ctrl;
  localparam logic [31:0] HA = 32'h0000_4180;
  localparam int          FC = 2;

  logic        clk = 1'b0, reset;
  logic        valid_m, bd_m, eret_m, cp0_interrupt, cp0_exception;
  logic [31:0] pc_m, cp0_epc;
  logic [4:0]  exc_carried_m, exc_new_m;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_pc, redirect_pc;
  logic        cp0_bd, cp0_eret, flush, pc_redirect, busy;
`ifdef EXC_STATS_EN
  logic [15:0] int_count, exc_count;
`endif

  exc_ctrl #(.HANDLER_ADDR(HA), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
    .exc_carried_m(exc_carried_m), .exc_new_m(exc_new_m), .eret_m(eret_m),
    .cp0_interrupt(cp0_interrupt), .cp0_exception(cp0_exception), .cp0_epc(cp0_epc),
    .cp0_exccode(cp0_exccode), .cp0_pc(cp0_pc), .cp0_bd(cp0_bd), .cp0_eret(cp0_eret),
    .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
`ifdef EXC_STATS_EN
    .int_count(int_count), .exc_count(exc_count),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model state: flush cycles still owed, post-redirect bubble tracking, event counts
  int          m_left;
  bit          m_pf;
  logic [31:0] m_resume;
  int          m_int, m_exc;

  task automatic model_reset();
    m_left = 0; m_pf = 0; m_resume = HA; m_int = 0; m_exc = 0;
  endtask

  task automatic idle();
    valid_m = 0; pc_m = 0; bd_m = 0; exc_carried_m = 0; exc_new_m = 0;
    eret_m = 0; cp0_interrupt = 0; cp0_exception = 0; cp0_epc = 0;
  endtask

  task automatic settle();
    bit run, tk, er, rd;
    logic [31:0] tgt;
    #1;
    run = (m_left == 0);
    tk  = run && (cp0_interrupt || cp0_exception);
    er  = run && valid_m && eret_m && !tk;
    rd  = tk || er;
    tgt = tk ? HA : (er ? cp0_epc : 32'd0);
    chk("exccode", 32'(cp0_exccode),
        (run && valid_m) ? 32'((exc_carried_m != 0) ? exc_carried_m : exc_new_m) : 32'd0);
    chk("cp0_pc", cp0_pc, (!valid_m && m_pf) ? m_resume : pc_m);
    chk("cp0_bd", 32'(cp0_bd), (!valid_m && m_pf) ? 32'd0 : 32'(bd_m));
    chk("cp0_eret", 32'(cp0_eret), 32'(er));
    chk("flush", 32'(flush), 32'(rd || !run));
    chk("pc_redirect", 32'(pc_redirect), 32'(rd));
    chk("redirect_pc", redirect_pc, tgt);
    chk("busy", 32'(busy), 32'(!run));
`ifdef EXC_STATS_EN
    chk("int_count", 32'(int_count), 32'(m_int));
    chk("exc_count", 32'(exc_count), 32'(m_exc));
`endif
  endtask

  task automatic adv();
    bit run, tk, er;
    run = (m_left == 0);
    tk  = run && (cp0_interrupt || cp0_exception);
    er  = run && valid_m && eret_m && !tk;
    if (tk) begin
      if (cp0_interrupt) m_int = (m_int < 65535) ? m_int + 1 : m_int;
      else               m_exc = (m_exc < 65535) ? m_exc + 1 : m_exc;
    end
    if (tk || er) begin
      m_resume = tk ? HA : cp0_epc;
      m_pf     = 1;
      m_left   = FC - 1;
    end else if (!run) begin
      m_left--;
    end else if (valid_m) begin
      m_pf = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    settle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    adv();

    // Carried Ov code with CP0 exception
    valid_m = 1; exc_carried_m = 5'd12; pc_m = 32'h3010; cp0_exception = 1;
    settle();
    chk("t1_exccode", 32'(cp0_exccode), 32'd12);
    chk("t1_cp0pc", cp0_pc, 32'h3010);
    chk("t1_redir", 32'(pc_redirect), 32'd1);
    chk("t1_rpc", redirect_pc, 32'h4180);
    adv();
    idle(); valid_m = 1; pc_m = 32'h4180;
    settle();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_flush", 32'(flush), 32'd1);
    chk("t1_noredir", 32'(pc_redirect), 32'd0);
    adv();

    // post_flush survives the FLUSH cycle; interrupt on the first RUN bubble
    idle(); pc_m = 32'hDEAD_0000; bd_m = 1; cp0_interrupt = 1;
    settle();
    chk("pf_cp0pc", cp0_pc, 32'h4180);
    chk("pf_bd", 32'(cp0_bd), 32'd0);
    chk("pf_rpc", redirect_pc, 32'h4180);
    adv();
    idle(); adv();

    // Precedence of carried over new code
    idle(); valid_m = 1; exc_carried_m = 5'd10; exc_new_m = 5'd4;
    settle();
    chk("prec_carried", 32'(cp0_exccode), 32'd10);
    adv();
    exc_carried_m = 0;
    settle();
    chk("prec_new", 32'(cp0_exccode), 32'd4);
    adv();

    // eret
    idle(); valid_m = 1; eret_m = 1; cp0_epc = 32'h3024;
    settle();
    chk("eret_out", 32'(cp0_eret), 32'd1);
    chk("eret_rpc", redirect_pc, 32'h3024);
    adv();
    idle();
    settle();
    chk("eret_flush", 32'(flush), 32'd1);
    chk("eret_noredir", 32'(pc_redirect), 32'd0);
    adv();

    // Interrupt beats eret; interrupt during FLUSH is ignored
    idle(); valid_m = 1; eret_m = 1; cp0_epc = 32'h5000; cp0_interrupt = 1;
    settle();
    chk("ie_eret", 32'(cp0_eret), 32'd0);
    chk("ie_rpc", redirect_pc, 32'h4180);
    adv();
    settle();
    chk("ie_flush_redir", 32'(pc_redirect), 32'd0);
    chk("ie_flush_eret", 32'(cp0_eret), 32'd0);
    adv();
    idle(); adv();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      valid_m       = ($urandom_range(99) < 70);
      pc_m          = $urandom & 32'hFFFF_FFFC;
      bd_m          = $urandom_range(1);
      exc_carried_m = ($urandom_range(1) != 0) ? 5'($urandom_range(31)) : 5'd0;
      exc_new_m     = ($urandom_range(1) != 0) ? 5'($urandom_range(31)) : 5'd0;
      eret_m        = ($urandom_range(99) < 15);
      cp0_interrupt = ($urandom_range(99) < 8);
      cp0_exception = ($urandom_range(99) < 8);
      cp0_epc       = $urandom & 32'hFFFF_FFFC;
      settle();
      adv();
    end

    // Async reset in the middle of FLUSH
    idle(); valid_m = 1; pc_m = 32'h1234; cp0_exception = 1;
    settle();
    adv();
    #2 reset = 0;
    #1;
    chk("ar_flush", 32'(flush), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cp0pc", cp0_pc, 32'd0);
    chk("ar_exccode", 32'(cp0_exccode), 32'd0);
    chk("ar_rpc", redirect_pc, 32'd0);
    model_reset();
    idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    settle();
    chk("ar_post_busy", 32'(busy), 32'd0);
`ifdef EXC_STATS_EN
    chk("ar_int_count", 32'(int_count), 32'd0);
    chk("ar_exc_count", 32'(exc_count), 32'd0);
`endif
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
